eth_ingress_arbiter: RTL

ETH_INGRESS_ARBITER -- requirements
Module: eth_ingress_arbiter

---
 rtl/eth_ingress_arbiter_if.sv | 72 +++++++
 rtl/eth_ingress_arbiter.sv | 221 ++++++++++++++++++++++
 2 files changed

// File: rtl/eth_ingress_arbiter_if.sv
// eth_ingress_arbiter_if
//   Bundles the ingress streams, the egress stream towards the IPv4 handler and
//   the metadata handshake of eth_ingress_arbiter.
//
//   s_tdata      NUM_PORTS*DATA_WIDTH  ingress data, port i at [i*DATA_WIDTH +: DATA_WIDTH]
//   s_tvalid     NUM_PORTS             ingress valid per port
//   s_tlast      NUM_PORTS             ingress end of frame per port
//   s_tready     NUM_PORTS             ingress ready per port (driven by arbiter)
//   m_tdata      DATA_WIDTH            egress data to handler
//   m_tvalid     1                     egress valid
//   m_tready     1                     handler ready
//   h_meta_valid 1                     handler metadata valid
//   h_meta_ready 1                     ready returned to handler
//   meta_valid   1                     metadata valid towards consumer
//   meta_ready   1                     consumer ready
//   meta_port    $clog2(NUM_PORTS)     port owning the metadata
//
//   Modport master is the arbiter side, slave is the surrounding environment.

`ifndef INPUTWIDTH
`define INPUTWIDTH 8
`endif

interface eth_ingress_arbiter_if #(
    parameter int unsigned NUM_PORTS  = 4,
    parameter int unsigned DATA_WIDTH = `INPUTWIDTH
);
    localparam int unsigned PORT_W = $clog2(NUM_PORTS);

    logic [NUM_PORTS*DATA_WIDTH-1:0] s_tdata;
    logic [NUM_PORTS-1:0]            s_tvalid;
    logic [NUM_PORTS-1:0]            s_tlast;
    logic [NUM_PORTS-1:0]            s_tready;
    logic [DATA_WIDTH-1:0]           m_tdata;
    logic                            m_tvalid;
    logic                            m_tready;
    logic                            h_meta_valid;
    logic                            h_meta_ready;
    logic                            meta_valid;
    logic                            meta_ready;
    logic [PORT_W-1:0]               meta_port;

    modport master (
        input  s_tdata,
        input  s_tvalid,
        input  s_tlast,
        output s_tready,
        output m_tdata,
        output m_tvalid,
        input  m_tready,
        input  h_meta_valid,
        output h_meta_ready,
        output meta_valid,
        input  meta_ready,
        output meta_port
    );

    modport slave (
        output s_tdata,
        output s_tvalid,
        output s_tlast,
        input  s_tready,
        input  m_tdata,
        input  m_tvalid,
        output m_tready,
        output h_meta_valid,
        input  h_meta_ready,
        input  meta_valid,
        output meta_ready,
        input  meta_port
    );
endinterface

// File: rtl/eth_ingress_arbiter.sv
// eth_ingress_arbiter
//   Round-robin arbiter that forwards whole frames from NUM_PORTS ingress byte
//   streams to a single IPv4 handler, waits for the handler's per-frame
//   metadata handshake, and drops frames that stall mid-frame for too long.
//
//   clk          in   sole clock, posedge
//   rst          in   synchronous, active-high reset
//   bus          if   eth_ingress_arbiter_if.master (streams + metadata handshake)
//   err_timeout  out  one-cycle pulse when a stalled frame is aborted
//   stat_frames  out  NUM_PORTS x 16-bit completed-frame counts
//   stat_drops   out  16-bit aborted-frame count
//
//   Optional feature: define ETH_ARB_STATS_EN to implement the saturating
//   statistics counters; otherwise stat_frames/stat_drops are tied to zero.

`ifndef INPUTWIDTH
`define INPUTWIDTH 8
`endif

module eth_ingress_arbiter #(
    parameter int unsigned NUM_PORTS     = 4,
    parameter int unsigned DATA_WIDTH    = `INPUTWIDTH,
    parameter int unsigned STALL_TIMEOUT = 1024
) (
    input  logic                   clk,
    input  logic                   rst,
    eth_ingress_arbiter_if.master  bus,
    output logic                   err_timeout,
    output logic [NUM_PORTS*16-1:0] stat_frames,
    output logic [15:0]            stat_drops
);
    localparam int unsigned PORT_W = $clog2(NUM_PORTS);

    typedef enum logic [1:0] {
        S_IDLE,
        S_STREAM,
        S_WAIT_META,
        S_FLUSH
    } state_e;

    state_e            state_r, state_nxt;
    logic [PORT_W-1:0] grant_r, grant_nxt;
    logic [PORT_W-1:0] last_grant_r, last_grant_nxt;
    logic [PORT_W-1:0] rr_pick;
    logic              meta_done_r, meta_done_nxt;
    logic [15:0]       stall_r, stall_nxt;
    logic              err_nxt;
    logic              frame_done;
    logic              drop_evt;
    logic              g_valid;
    logic              g_last;
    logic              beat_acc;
    logic              meta_hs;

    logic [DATA_WIDTH-1:0] port_data [NUM_PORTS];

    for (genvar i = 0; i < NUM_PORTS; i++) begin : g_lane
        assign port_data[i] = bus.s_tdata[i*DATA_WIDTH +: DATA_WIDTH];
    end

    assign g_valid       = bus.s_tvalid[grant_r];
    assign g_last        = bus.s_tlast[grant_r];
    assign bus.meta_port = grant_r;

    // First requester strictly after last_grant_r, wrapping; scanning from the
    // nearest candidate outward keeps the search a simple priority chain.
    always_comb begin
        int unsigned idx;
        logic        found;
        idx     = 0;
        found   = 1'b0;
        rr_pick = last_grant_r;
        for (int unsigned k = 1; k <= NUM_PORTS; k++) begin
            idx = (32'(last_grant_r) + k) % NUM_PORTS;
            if (!found && bus.s_tvalid[PORT_W'(idx)]) begin
                found   = 1'b1;
                rr_pick = PORT_W'(idx);
            end
        end
    end

    always_comb begin
        state_nxt        = state_r;
        grant_nxt        = grant_r;
        last_grant_nxt   = last_grant_r;
        meta_done_nxt    = meta_done_r;
        stall_nxt        = stall_r;
        err_nxt          = 1'b0;
        frame_done       = 1'b0;
        drop_evt         = 1'b0;
        beat_acc         = 1'b0;
        meta_hs          = 1'b0;
        bus.s_tready     = '0;
        bus.m_tdata      = '0;
        bus.m_tvalid     = 1'b0;
        bus.meta_valid   = 1'b0;
        bus.h_meta_ready = 1'b0;

        unique case (state_r)
            S_IDLE: begin
                meta_done_nxt = 1'b0;
                stall_nxt     = '0;
                if (|bus.s_tvalid) begin
                    grant_nxt = rr_pick;
                    state_nxt = S_STREAM;
                end
            end

            S_STREAM: begin
                bus.m_tdata           = port_data[grant_r];
                bus.m_tvalid          = g_valid;
                bus.s_tready[grant_r] = bus.m_tready;
                bus.meta_valid        = bus.h_meta_valid;
                bus.h_meta_ready      = bus.meta_ready;
                beat_acc              = g_valid && bus.m_tready;
                meta_hs               = bus.h_meta_valid && bus.meta_ready;

                if (beat_acc) begin
                    stall_nxt = '0;
                    if (g_last) begin
                        meta_done_nxt = 1'b0;
                        // Metadata already seen (earlier or this very cycle):
                        // the frame is complete, skip S_WAIT_META.
                        if (meta_done_r || meta_hs) begin
                            state_nxt      = S_IDLE;
                            last_grant_nxt = grant_r;
                            frame_done     = 1'b1;
                        end else begin
                            state_nxt = S_WAIT_META;
                        end
                    end else if (meta_hs) begin
                        meta_done_nxt = 1'b1;
                    end
                end else begin
                    if (meta_hs) begin
                        meta_done_nxt = 1'b1;
                    end
                    if (stall_r == 16'(STALL_TIMEOUT - 1)) begin
                        err_nxt       = 1'b1;
                        drop_evt      = 1'b1;
                        meta_done_nxt = 1'b0;
                        stall_nxt     = '0;
                        state_nxt     = S_FLUSH;
                    end else begin
                        stall_nxt = stall_r + 16'd1;
                    end
                end
            end

            S_WAIT_META: begin
                bus.meta_valid   = bus.h_meta_valid;
                bus.h_meta_ready = bus.meta_ready;
                if (bus.h_meta_valid && bus.meta_ready) begin
                    state_nxt      = S_IDLE;
                    last_grant_nxt = grant_r;
                    frame_done     = 1'b1;
                end
            end

            S_FLUSH: begin
                // Drain the aborted frame up to its tlast without forwarding.
                bus.s_tready[grant_r] = 1'b1;
                if (g_valid && g_last) begin
                    state_nxt      = S_IDLE;
                    last_grant_nxt = grant_r;
                end
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_r      <= S_IDLE;
            grant_r      <= '0;
            last_grant_r <= PORT_W'(NUM_PORTS - 1);
            meta_done_r  <= 1'b0;
            stall_r      <= '0;
            err_timeout  <= 1'b0;
        end else begin
            state_r      <= state_nxt;
            grant_r      <= grant_nxt;
            last_grant_r <= last_grant_nxt;
            meta_done_r  <= meta_done_nxt;
            stall_r      <= stall_nxt;
            err_timeout  <= err_nxt;
        end
    end

`ifdef ETH_ARB_STATS_EN
    logic [15:0] frames_r [NUM_PORTS];
    logic [15:0] drops_r;

    // Saturating counters: hold at 16'hFFFF instead of wrapping.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < NUM_PORTS; i++) begin
                frames_r[i] <= '0;
            end
            drops_r <= '0;
        end else begin
            if (frame_done && (frames_r[grant_r] != 16'hFFFF)) begin
                frames_r[grant_r] <= frames_r[grant_r] + 16'd1;
            end
            if (drop_evt && (drops_r != 16'hFFFF)) begin
                drops_r <= drops_r + 16'd1;
            end
        end
    end

    for (genvar i = 0; i < NUM_PORTS; i++) begin : g_stat_pack
        assign stat_frames[i*16 +: 16] = frames_r[i];
    end
    assign stat_drops = drops_r;
`else
    logic unused_stats;
    assign unused_stats = frame_done ^ drop_evt;
    assign stat_frames  = '0;
    assign stat_drops   = '0;
`endif

endmodule
